// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between the instruction/data requesters, the
// arbiter and the single-port RAM.
//
// Handshake: a requester raises *_req with its command stable and holds it
// until the matching *_ack pulse (one cycle). The arbiter answers each
// granted request with exactly one ack. Dropping *_req before a grant
// withdraws the request. Commands are sampled only at the grant edge.
//
// Port summary
//   i_req/i_addr            fetch request and address (requester -> arbiter)
//   i_data/i_ack            fetch read data and completion pulse
//   d_req/d_addr/d_wr_data  data request, address, write data
//   d_bytesel/d_wr_en       byte lanes and write flag
//   d_rd_data/d_ack         data read result and completion pulse
//   m_cs/m_addr/m_wr_data   RAM strobe and command (arbiter -> RAM)
//   m_bytesel/m_wr_en       RAM byte lanes and write flag
//   m_rd_data               RAM read data (RAM -> arbiter)
//
// Modports: slave is the arbiter; master is everything around it
// (requesters plus the RAM).
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        i_ack;

    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wr_data;
    logic [3:0]  d_bytesel;
    logic        d_wr_en;
    logic [31:0] d_rd_data;
    logic        d_ack;

    logic        m_cs;
    logic [31:0] m_addr;
    logic [31:0] m_wr_data;
    logic [3:0]  m_bytesel;
    logic        m_wr_en;
    logic [31:0] m_rd_data;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_wr_data, d_bytesel, d_wr_en,
        input  m_rd_data,
        output i_data, i_ack, d_rd_data, d_ack,
        output m_cs, m_addr, m_wr_data, m_bytesel, m_wr_en
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, d_wr_data, d_bytesel, d_wr_en,
        output m_rd_data,
        input  i_data, i_ack, d_rd_data, d_ack,
        input  m_cs, m_addr, m_wr_data, m_bytesel, m_wr_en
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between an instruction fetch port
// and a data port. One access is in flight at a time, three cycles each:
// grant (IDLE) -> access strobe (I_ACC/D_ACC) -> ack (I_RSP/D_RSP).
//
// Data requests win ties, but after MAX_DATA_RUN consecutive data grants made
// while a fetch was waiting, the fetch gets the next slot.
//
// Ports
//   clk        clock, everything changes on the rising edge
//   rst_n      asynchronous active-low reset; aborts any access in flight
//   bus        mem_arbiter_if.slave, requester and RAM signals
//   dbg_state  current FSM state (state_t encoding) for observation
module mem_arbiter #(
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_arbiter_if.slave       bus,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        I_ACC = 3'd1,
        D_ACC = 3'd2,
        I_RSP = 3'd3,
        D_RSP = 3'd4
    } state_t;

    localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

    state_t     state;
    logic [3:0] run_cnt;
    logic       run_at_max;
    logic       grant_d;

    assign run_at_max = (run_cnt == RUN_MAX);
    // Data wins unless a fetch has been starved for a full run.
    assign grant_d    = bus.d_req && !(bus.i_req && run_at_max);
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            run_cnt       <= 4'd0;
            bus.i_data    <= 32'd0;
            bus.i_ack     <= 1'b0;
            bus.d_rd_data <= 32'd0;
            bus.d_ack     <= 1'b0;
            bus.m_cs      <= 1'b0;
            bus.m_addr    <= 32'd0;
            bus.m_wr_data <= 32'd0;
            bus.m_bytesel <= 4'd0;
            bus.m_wr_en   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        bus.m_cs      <= 1'b1;
                        bus.m_addr    <= bus.d_addr;
                        bus.m_wr_data <= bus.d_wr_data;
                        bus.m_bytesel <= bus.d_bytesel;
                        bus.m_wr_en   <= bus.d_wr_en;
                        // Only grants that overtake a waiting fetch count.
                        if (!bus.i_req) begin
                            run_cnt <= 4'd0;
                        end else if (!run_at_max) begin
                            run_cnt <= run_cnt + 4'd1;
                        end
                        state <= D_ACC;
                    end else if (bus.i_req) begin
                        bus.m_cs      <= 1'b1;
                        bus.m_addr    <= bus.i_addr;
                        bus.m_wr_data <= 32'd0;
                        bus.m_bytesel <= 4'hF;
                        bus.m_wr_en   <= 1'b0;
                        run_cnt       <= 4'd0;
                        state         <= I_ACC;
                    end
                end
                I_ACC: begin
                    bus.m_cs    <= 1'b0;
                    bus.m_wr_en <= 1'b0;
                    bus.i_ack   <= 1'b1;
                    bus.i_data  <= bus.m_rd_data;
                    state       <= I_RSP;
                end
                D_ACC: begin
                    bus.m_cs    <= 1'b0;
                    bus.m_wr_en <= 1'b0;
                    bus.d_ack   <= 1'b1;
                    // m_wr_en still holds this access's direction here.
                    if (!bus.m_wr_en) begin
                        bus.d_rd_data <= bus.m_rd_data;
                    end
                    state <= D_RSP;
                end
                I_RSP: begin
                    bus.i_ack <= 1'b0;
                    state     <= IDLE;
                end
                D_RSP: begin
                    bus.d_ack <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
